muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair for the single-cycle MIPS core. The control decoder's MULT/MTHI/MTLO/MFHI/MFLO signals map onto this block's `op`, `start` and `rd_req` inputs. The block runs signed/unsigned multiply (and optionally divide) one bit per cycle and raises `stall` to freeze PC/regfile writes while a result is pending. HI/LO feed the MFHI/MFLO writeback mux.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_iter.sv | 44 ++++
 rtl/muldiv_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One shift-add (multiply) or restoring shift-subtract (divide) step on the accumulator.
// The divide step is only built when MULDIV_DIV_EN is defined.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_next;

  // Multiplier bits sit in the low half and are consumed from bit 0.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {sum, acc[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;

  // Upper half is the partial remainder, low half shifts dividend out and quotient in.
  always_comb begin
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, operand};
    if (diff[WIDTH]) begin
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  assign acc_next = mode ? div_next : mul_next;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign acc_next    = mul_next;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative mul/div sequencer owning HI/LO; stalls the core while a result is pending.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned    CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               done_q, done_d;
  logic               iter_mode;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_DIV_EN
  logic is_div_q, is_div_d, neg_rem_q, neg_rem_d;
  assign iter_mode = is_div_q;
`else
  assign iter_mode = 1'b0;
`endif

  muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .acc     (acc_q),
    .operand (opnd_q),
    .mode    (iter_mode),
    .acc_next(acc_step)
  );

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | rd_req);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    prod      = neg_res_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MULT || op == OP_MULTU) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            acc_d     = {{WIDTH{1'b0}}, b_mag};
            opnd_d    = a_mag;
            neg_res_d = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            is_div_d  = 1'b0;
            neg_rem_d = 1'b0;
`endif
          end
`ifdef MULDIV_DIV_EN
          else if (op == OP_DIV || op == OP_DIVU) begin
            is_div_d = 1'b1;
            cnt_d    = '0;
            opnd_d   = b_mag;
            // Zero divisor: result is preloaded raw, FIX applies no correction.
            if (b == '0) begin
              state_d   = S_FIX;
              acc_d     = {a, {WIDTH{1'b1}}};
              neg_res_d = 1'b0;
              neg_rem_d = 1'b0;
            end else begin
              state_d   = S_RUN;
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
            end
          end
`endif
          else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        if (cnt_q == CntLast) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else
`endif
        begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      done_q    <= done_d;
    end
  end

`ifdef MULDIV_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised self-checking bench for muldiv_ctrl against an arithmetic reference model.
// Divide checks follow MULDIV_DIV_EN; without it DIV/DIVU must behave as no-ops.
module tb_muldiv_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, rd_req;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] hi_m, lo_m;

  muldiv_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rd_req(rd_req),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // {hi, lo} of the full product.
  function automatic logic [63:0] model_mul(input logic [2:0] o, input logic [31:0] x, y);
    longint sx, sy;
    if (o == 3'd0) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    return sx * sy;
  endfunction

`ifdef MULDIV_DIV_EN
  // {hi=remainder, lo=quotient}, truncating division.
  function automatic logic [63:0] model_div(input logic [2:0] o, input logic [31:0] x, y);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({32'b0, x});
      sy = longint'({32'b0, y});
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction
`endif

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  // Presents one op for a cycle, then counts busy cycles and done pulses (bounded).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] va, vb,
                       output int bcyc, output int dcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0; dcnt = 0;
    while (busy && bcyc < 100) begin
      bcyc++;
      if (done) dcnt++;
      @(negedge clk);
    end
    if (done) dcnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rd_req = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (hi !== '0) begin failures++; $display("FAIL rst_hi got=%h want=0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("FAIL rst_lo got=%h want=0", lo); end
    rst = 1'b0;
    rd_req = 1'b1; start = 1'b1; op = 3'd6;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b want=0", stall); end
    rd_req = 1'b0; start = 1'b0;
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_mul();
    int bc, dc;
    logic [2:0] o;
    logic [W-1:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 26; i++) begin
      if (i == 0) begin o = 3'd0; x = 32'hFFFF_FFFD; y = 32'd7; end
      else if (i == 1) begin o = 3'd1; x = 32'hFFFF_FFFD; y = 32'd7; end
      else begin o = 3'($urandom_range(0, 1)); x = pick(); y = pick(); end
      e = model_mul(o, x, y);
      issue(o, x, y, bc, dc);
      hi_m = e[63:32]; lo_m = e[31:0];
      checks++; if (hi !== hi_m) begin failures++; $display("FAIL mul_hi op=%0d a=%h b=%h got=%h want=%h", o, x, y, hi, hi_m); end
      checks++; if (lo !== lo_m) begin failures++; $display("FAIL mul_lo op=%0d a=%h b=%h got=%h want=%h", o, x, y, lo, lo_m); end
      checks++; if (bc != W + 1) begin failures++; $display("FAIL mul_busy_cycles got=%0d want=%0d", bc, W + 1); end
      checks++; if (dc != 1) begin failures++; $display("FAIL mul_done_pulses got=%0d want=1", dc); end
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    int bc, dc;
    logic [2:0] o;
    logic [W-1:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 26; i++) begin
      case (i)
        0: begin o = 3'd2; x = 32'hFFFF_FFF9; y = 32'd2; end
        1: begin o = 3'd3; x = 32'd100; y = 32'd7; end
        2: begin o = 3'd2; x = 32'd5; y = 32'd0; end
        3: begin o = 3'd2; x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        4: begin o = 3'd3; x = 32'hFFFF_FFFF; y = 32'd0; end
        default: begin o = 3'($urandom_range(2, 3)); x = pick(); y = pick(); end
      endcase
      e = model_div(o, x, y);
      issue(o, x, y, bc, dc);
      hi_m = e[63:32]; lo_m = e[31:0];
      checks++; if (hi !== hi_m) begin failures++; $display("FAIL div_hi op=%0d a=%h b=%h got=%h want=%h", o, x, y, hi, hi_m); end
      checks++; if (lo !== lo_m) begin failures++; $display("FAIL div_lo op=%0d a=%h b=%h got=%h want=%h", o, x, y, lo, lo_m); end
      checks++; if (bc != ((y == 0) ? 1 : W + 1)) begin failures++; $display("FAIL div_busy_cycles b=%h got=%0d", y, bc); end
      checks++; if (dc != 1) begin failures++; $display("FAIL div_done_pulses got=%0d want=1", dc); end
    end
  endtask
`else
  task automatic test_div_disabled();
    int bc, dc;
    for (int i = 0; i < 6; i++) begin
      issue(3'(2 + (i % 2)), pick(), pick(), bc, dc);
      checks++; if (bc != 0) begin failures++; $display("FAIL nodiv_busy got=%0d want=0", bc); end
      checks++; if (dc != 0) begin failures++; $display("FAIL nodiv_done got=%0d want=0", dc); end
      checks++; if (hi !== hi_m) begin failures++; $display("FAIL nodiv_hi got=%h want=%h", hi, hi_m); end
      checks++; if (lo !== lo_m) begin failures++; $display("FAIL nodiv_lo got=%h want=%h", lo, lo_m); end
    end
  endtask
`endif

  task automatic test_noop();
    int bc, dc;
    for (int i = 6; i < 8; i++) begin
      issue(3'(i), $urandom(), $urandom(), bc, dc);
      checks++; if (bc != 0 || dc != 0) begin failures++; $display("FAIL noop_busy_done op=%0d got=%0d/%0d want=0/0", i, bc, dc); end
      checks++; if (hi !== hi_m || lo !== lo_m) begin failures++; $display("FAIL noop_hilo got=%h/%h want=%h/%h", hi, lo, hi_m, lo_m); end
    end
  endtask

  task automatic test_mthi_mtlo();
    int bc, dc, n;
    logic [W-1:0] x, y, nv;
    logic [63:0] e;
    issue(3'd4, 32'h1234_5678, $urandom(), bc, dc);
    hi_m = 32'h1234_5678;
    checks++; if (hi !== hi_m) begin failures++; $display("FAIL mthi_idle got=%h want=%h", hi, hi_m); end
    checks++; if (bc != 0 || dc != 0) begin failures++; $display("FAIL mthi_busy_done got=%0d/%0d want=0/0", bc, dc); end
    nv = $urandom();
    issue(3'd5, nv, $urandom(), bc, dc);
    lo_m = nv;
    checks++; if (lo !== lo_m || hi !== hi_m) begin failures++; $display("FAIL mtlo_idle got=%h/%h want=%h/%h", hi, lo, hi_m, lo_m); end
    // MTHI presented mid-multiply and held until accepted.
    x = $urandom(); y = $urandom(); nv = $urandom();
    e = model_mul(3'd1, x, y);
    @(negedge clk); start = 1'b1; op = 3'd1; a = x; b = y;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd4; a = nv;
    n = 0;
    while (busy && n < 100) begin
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mthi_busy_stall got=%b want=1", stall); end
      checks++; if (hi !== hi_m) begin failures++; $display("FAIL mthi_busy_hi got=%h want=%h", hi, hi_m); end
      n++;
      @(negedge clk);
    end
    hi_m = e[63:32]; lo_m = e[31:0];
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mthi_release_stall got=%b want=0", stall); end
    checks++; if (hi !== hi_m) begin failures++; $display("FAIL mthi_mul_hi got=%h want=%h", hi, hi_m); end
    @(negedge clk); start = 1'b0;
    hi_m = nv;
    checks++; if (hi !== hi_m || lo !== lo_m) begin failures++; $display("FAIL mthi_after_mul got=%h/%h want=%h/%h", hi, lo, hi_m, lo_m); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mthi_done got=%b want=0", done); end
  endtask

  task automatic test_rd_stall();
    int n;
    logic [W-1:0] x, y;
    logic [63:0] e;
    x = $urandom(); y = $urandom();
    e = model_mul(3'd0, x, y);
    @(negedge clk); start = 1'b1; op = 3'd0; a = x; b = y;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rd_req = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mfhi_stall got=%b want=1", stall); end
      n++;
      @(negedge clk);
    end
    hi_m = e[63:32]; lo_m = e[31:0];
    checks++; if (n != W - 3) begin failures++; $display("FAIL mfhi_stall_cycles got=%0d want=%0d", n, W - 3); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mfhi_release got=%b want=0", stall); end
    checks++; if (hi !== hi_m) begin failures++; $display("FAIL mfhi_hi got=%h want=%h", hi, hi_m); end
    rd_req = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int bc, dc;
    logic [63:0] e;
    issue(3'd4, 32'hA5A5_A5A5, '0, bc, dc);
    issue(3'd5, 32'h5A5A_5A5A, '0, bc, dc);
    @(negedge clk); start = 1'b1; op = 3'd0; a = $urandom(); b = $urandom();
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_busy_done got=%b/%b want=0/0", busy, done); end
    checks++; if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL midrst_hilo got=%h/%h want=0/0", hi, lo); end
    @(negedge clk); rst = 1'b0;
    e = model_mul(3'd1, 32'd2, 32'd3);
    issue(3'd1, 32'd2, 32'd3, bc, dc);
    hi_m = e[63:32]; lo_m = e[31:0];
    checks++; if (hi !== hi_m || lo !== lo_m) begin failures++; $display("FAIL postrst_mul got=%h/%h want=%h/%h", hi, lo, hi_m, lo_m); end
    checks++; if (bc != W + 1) begin failures++; $display("FAIL postrst_busy got=%0d want=%0d", bc, W + 1); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [W-1:0] x1, y1, x2, y2;
    logic [63:0] e1, e2;
    x1 = pick(); y1 = pick(); x2 = pick(); y2 = pick();
    e1 = model_mul(3'd0, x1, y1);
    e2 = model_mul(3'd1, x2, y2);
    @(negedge clk); start = 1'b1; op = 3'd0; a = x1; b = y1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b want=1", done); end
    checks++; if (hi !== e1[63:32] || lo !== e1[31:0]) begin failures++; $display("FAIL b2b_res1 got=%h/%h want=%h/%h", hi, lo, e1[63:32], e1[31:0]); end
    start = 1'b1; op = 3'd1; a = x2; b = y2;
    @(negedge clk); start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b want=1", busy); end
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    hi_m = e2[63:32]; lo_m = e2[31:0];
    checks++; if (n != W + 1) begin failures++; $display("FAIL b2b_busy2 got=%0d want=%0d", n, W + 1); end
    checks++; if (hi !== hi_m || lo !== lo_m) begin failures++; $display("FAIL b2b_res2 got=%h/%h want=%h/%h", hi, lo, hi_m, lo_m); end
  endtask

  initial begin
    test_reset();
    test_mul();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_noop();
    test_mthi_mtlo();
    test_rd_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
